text_overlay_gen: RTL and testbench

//  Parametrised text-overlay generator for the VGA pixel path. Renders an N_CHARS-wide string from a

---
 rtl/text_overlay_gen.sv | 145 ++++++++++++++
 tb/tb_text_overlay_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_gen.sv
// text_overlay_gen: renders an N_CHARS string from a writable character buffer
// at pixel origin (X0,Y0) with 2**SCALE_LOG2 glyph scaling, blink and inverse video.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   video_on               display-area flag from the sync generator
//   pixel_x, pixel_y       current pixel coordinates (10 bit)
//   fg_color               glyph colour
//   blink_en, invert       blink glyph pixels / swap fg and bg inside the box
//   wr_en, wr_idx, wr_char character buffer write port
//   rom_addr               font ROM address {char, row}, combinational
//   font_word              font ROM data, one clock after rom_addr
//   text_on, rgb_text      registered box flag and pixel colour (2-clk latency)
module text_overlay_gen #(
  parameter int unsigned N_CHARS      = 8,
  parameter int unsigned X0           = 304,
  parameter int unsigned Y0           = 240,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [2:0]  BG_COLOR     = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [2:0]  fg_color,
  input  logic        blink_en,
  input  logic        invert,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [6:0]  wr_char,
  output logic [10:0] rom_addr,
  input  logic [7:0]  font_word,
  output logic        text_on,
  output logic [2:0]  rgb_text
);

  localparam int unsigned SCALE = 1 << SCALE_LOG2;
  localparam int unsigned BOX_W = N_CHARS * 8 * SCALE;
  localparam int unsigned BOX_H = 16 * SCALE;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned BUF_D = 16;

  logic [6:0]       r_buf [BUF_D];
  logic [2:0]       r_bit;
  logic             r_in_box;
  logic             r_video_on;
  logic             r_origin;
  logic             r_origin_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [2:0]       r_rgb;
  logic             r_text_on;

  logic [9:0] w_rel_x;
  logic [9:0] w_rel_y;
  logic       w_in_box;
  logic [3:0] w_idx;
  logic [3:0] w_row;
  logic [2:0] w_bit;
  logic [6:0] w_char;
  logic       w_tick;
  logic       w_lit;
  logic [2:0] w_rgb;

  // Stage 0: box geometry and font ROM address
  always_comb begin
    w_rel_x  = pixel_x - 10'(X0);
    w_rel_y  = pixel_y - 10'(Y0);
    w_in_box = (pixel_x >= 10'(X0)) && (w_rel_x < 10'(BOX_W)) &&
               (pixel_y >= 10'(Y0)) && (w_rel_y < 10'(BOX_H));
    w_idx    = 4'(w_rel_x >> (3 + SCALE_LOG2));
    w_row    = 4'(w_rel_y >> SCALE_LOG2);
    w_bit    = 3'(w_rel_x >> SCALE_LOG2);
    w_char   = w_in_box ? r_buf[w_idx] : 7'h00;
    rom_addr = {w_char, w_row};
  end

  // Character buffer; indices beyond the string length are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_D; i++) r_buf[i] <= 7'h00;
    end else if (wr_en && ({1'b0, wr_idx} < 5'(N_CHARS))) begin
      r_buf[wr_idx] <= wr_char;
    end
  end

  // Stage 1: align position info with the ROM data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit      <= 3'd0;
      r_in_box   <= 1'b0;
      r_video_on <= 1'b0;
    end else begin
      r_bit      <= w_bit;
      r_in_box   <= w_in_box;
      r_video_on <= video_on;
    end
  end

  // Frame tick: rising edge of the registered top-left-pixel flag
  assign w_tick = r_origin & ~r_origin_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_origin   <= 1'b0;
      r_origin_d <= 1'b0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_origin   <= (pixel_x == 10'd0) && (pixel_y == 10'd0);
      r_origin_d <= r_origin;
      if (w_tick) begin
        if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stage 2 colour select; font bit 7 is the leftmost pixel
  always_comb begin
    w_lit = font_word[~r_bit] & ~(blink_en & r_phase);
    w_rgb = BG_COLOR;
    if (!r_video_on)   w_rgb = 3'b000;
    else if (r_in_box) w_rgb = (w_lit ^ invert) ? fg_color : BG_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb     <= 3'b000;
      r_text_on <= 1'b0;
    end else begin
      r_rgb     <= w_rgb;
      r_text_on <= r_in_box;
    end
  end

  assign rgb_text = r_rgb;
  assign text_on  = r_text_on;

endmodule

// File: tb/tb_text_overlay_gen.sv
// Directed bench: dut_a is 1x scale with a 2-frame blink period, dut_b is 2x scale.
// The font ROM model returns rom_addr[7:0] so expected pixels can be worked by hand.
module tb_text_overlay_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic [2:0]  fg_color;
  logic        blink_en, invert;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [6:0]  wr_char;
  logic [10:0] rom_addr_a, rom_addr_b;
  logic [7:0]  font_a, font_b;
  logic        text_on_a, text_on_b;
  logic [2:0]  rgb_a, rgb_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  text_overlay_gen #(.BLINK_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .fg_color(fg_color), .blink_en(blink_en), .invert(invert), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_char(wr_char), .rom_addr(rom_addr_a), .font_word(font_a),
    .text_on(text_on_a), .rgb_text(rgb_a));

  text_overlay_gen #(.SCALE_LOG2(1)) dut_b (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .fg_color(fg_color), .blink_en(blink_en), .invert(invert), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_char(wr_char), .rom_addr(rom_addr_b), .font_word(font_b),
    .text_on(text_on_b), .rgb_text(rgb_b));

  // Synchronous font ROM models
  always @(posedge clk) begin
    font_a <= rom_addr_a[7:0];
    font_b <= rom_addr_b[7:0];
  end

  typedef struct {
    int b;     // 0 = dut_a, 1 = dut_b
    int x, y, vid, inv, blk;
    int addr, rgb, on;
  } vec_t;

  vec_t vt [29];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int idx, input int ch);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_char = 7'(ch);
    step();
    wr_en = 1'b0;
  endtask

  // Present coords, check rom_addr now and pixel after the 2-clk pipeline
  task automatic apply(input vec_t v, input string nm);
    pixel_x = 10'(v.x); pixel_y = 10'(v.y);
    video_on = 1'(v.vid); invert = 1'(v.inv); blink_en = 1'(v.blk);
    #1;
    chk({nm, " rom_addr"}, (v.b != 0) ? int'(rom_addr_b) : int'(rom_addr_a), v.addr);
    step();
    step();
    chk({nm, " rgb_text"}, (v.b != 0) ? int'(rgb_b) : int'(rgb_a), v.rgb);
    chk({nm, " text_on"}, (v.b != 0) ? int'(text_on_b) : int'(text_on_a), v.on);
  endtask

  task automatic frame_tick();
    pixel_x = 10'd0; pixel_y = 10'd0;
    step();
  endtask

  initial begin
    vec_t v;
    // 'J'=4A 'M'=4D 'G'=47 in slots 0..2, fg = red, row 4 -> font bytes A4/D4/74
    vt[0]  = '{0, 304, 244, 1, 0, 0, 'h4A4, 4, 1};
    vt[1]  = '{0, 305, 244, 1, 0, 0, 'h4A4, 3, 1};
    vt[2]  = '{0, 306, 244, 1, 0, 0, 'h4A4, 4, 1};
    vt[3]  = '{0, 311, 244, 1, 0, 0, 'h4A4, 3, 1};
    vt[4]  = '{0, 312, 244, 1, 0, 0, 'h4D4, 4, 1};
    vt[5]  = '{0, 314, 244, 1, 0, 0, 'h4D4, 3, 1};
    vt[6]  = '{0, 320, 244, 1, 0, 0, 'h474, 3, 1};
    vt[7]  = '{0, 321, 244, 1, 0, 0, 'h474, 4, 1};
    vt[8]  = '{0, 303, 244, 1, 0, 0, 'h004, 3, 0};
    vt[9]  = '{0, 328, 244, 1, 0, 0, 'h004, 3, 1};
    vt[10] = '{0, 333, 244, 1, 0, 0, 'h004, 4, 1};
    vt[11] = '{0, 368, 244, 1, 0, 0, 'h004, 3, 0};
    vt[12] = '{0, 304, 239, 1, 0, 0, 'h00F, 3, 0};
    vt[13] = '{0, 304, 255, 1, 0, 0, 'h4AF, 4, 1};
    vt[14] = '{0, 304, 256, 1, 0, 0, 'h000, 3, 0};
    vt[15] = '{0, 304, 244, 1, 1, 0, 'h4A4, 3, 1};
    vt[16] = '{0, 305, 244, 1, 1, 0, 'h4A4, 4, 1};
    vt[17] = '{0, 303, 244, 1, 1, 0, 'h004, 3, 0};
    vt[18] = '{0, 304, 244, 0, 0, 0, 'h4A4, 0, 1};
    vt[19] = '{0, 100, 100, 0, 0, 0, 'h004, 0, 0};
    // 2x scale: 'J' covers x 304-319, y 240-271
    vt[20] = '{1, 304, 248, 1, 0, 0, 'h4A4, 4, 1};
    vt[21] = '{1, 305, 248, 1, 0, 0, 'h4A4, 4, 1};
    vt[22] = '{1, 306, 248, 1, 0, 0, 'h4A4, 3, 1};
    vt[23] = '{1, 319, 248, 1, 0, 0, 'h4A4, 3, 1};
    vt[24] = '{1, 320, 248, 1, 0, 0, 'h4D4, 4, 1};
    vt[25] = '{1, 304, 249, 1, 0, 0, 'h4A4, 4, 1};
    vt[26] = '{1, 304, 271, 1, 0, 0, 'h4AF, 4, 1};
    vt[27] = '{1, 304, 272, 1, 0, 0, 'h000, 3, 0};
    vt[28] = '{1, 304, 240, 1, 0, 0, 'h4A0, 4, 1};

    reset = 1'b1; video_on = 1'b1; fg_color = 3'b100; blink_en = 1'b0; invert = 1'b0;
    wr_en = 1'b0; wr_idx = 4'd0; wr_char = 7'd0; pixel_x = 10'd304; pixel_y = 10'd244;

    // Held in reset with arbitrary coordinates
    for (int i = 0; i < 4; i++) begin
      pixel_x = 10'($urandom_range(1, 639));
      pixel_y = 10'($urandom_range(1, 479));
      step();
      chk("reset rgb_text", int'(rgb_a), 0);
      chk("reset text_on", int'(text_on_a), 0);
      chk("reset rom_addr hi", int'(rom_addr_a[10:4]), 0);
      chk("reset rom_addr hi b", int'(rom_addr_b[10:4]), 0);
    end
    pixel_x = 10'd304; pixel_y = 10'd244;
    step();
    reset = 1'b0;
    step();

    wr(0, 'h4A);
    wr(1, 'h4D);
    wr(2, 'h47);

    for (int i = 0; i < 29; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Blink with a 2-frame half period
    v = '{0, 304, 244, 1, 0, 1, 'h4A4, 4, 1};
    apply(v, "blink f0 visible");
    frame_tick();
    apply(v, "blink f1 visible");
    frame_tick();
    v.rgb = 3;
    apply(v, "blink f2 hidden");
    frame_tick();
    apply(v, "blink f3 hidden");
    v.blk = 0; v.rgb = 4;
    apply(v, "blink_en off");
    v.blk = 1; v.rgb = 3;
    apply(v, "blink_en back on");
    frame_tick();
    v.rgb = 4;
    apply(v, "blink f4 visible");

    // Out-of-range writes leave the string intact
    wr(8, 'h5A);
    wr(15, 'h5A);
    apply('{0, 304, 244, 1, 0, 0, 'h4A4, 4, 1}, "oob slot0");
    apply('{0, 328, 244, 1, 0, 0, 'h004, 3, 1}, "oob slot3");

    // Reset pulse mid-line
    pixel_x = 10'd304; pixel_y = 10'd244; video_on = 1'b1; blink_en = 1'b0; invert = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset rgb_text", int'(rgb_a), 0);
    chk("midreset text_on", int'(text_on_a), 0);
    chk("midreset rom_addr", int'(rom_addr_a), 'h004);
    chk("midreset rom_addr b", int'(rom_addr_b), 'h002);
    step();
    reset = 1'b0;
    step();
    chk("post-reset clk1 rgb_text", int'(rgb_a), 0);
    step();
    chk("post-reset clk2 rgb_text", int'(rgb_a), 3);
    chk("post-reset clk2 text_on", int'(text_on_a), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
